// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg: opcodes, ALU/MU op codes and result-select codes shared by the EX-stage control decode.
package ex_ctrl_pkg;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;
  typedef enum logic [1:0] {MU_MUL, MU_MULH, MU_MULHSU, MU_MULHU} mu_op_e;
  localparam int RES_ALU = 0;
  localparam int RES_MU  = 1;
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: combinational opcode/func3/func7 -> ALU op; illegal flag only with EX_ILLEGAL_DETECT_EN.
module alu_op_decoder
  import ex_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [1:0] func7b50,
  output logic [3:0] aluctl,
  output logic       illegal
);
  always_comb begin
    aluctl = ALU_ADD;
    case (opcode)
      OP:                            aluctl = func7b50[0] ? ALU_ADD : arith_op(func3, func7b50[1]);
      OP_IMM:                        aluctl = arith_op(func3, func3 == 3'b101 && func7b50[1]);
      LUI:                           aluctl = ALU_PASSB;
      BRANCH:                        aluctl = func3[2] ? (func3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      AUIPC, LOAD, STORE, JAL, JALR: aluctl = ALU_ADD;
      default:                       aluctl = ALU_ADD;
    endcase
  end
`ifdef EX_ILLEGAL_DETECT_EN
  // DIV/REM and func7b50=11 are rejected here alongside unknown opcodes
  assign illegal = !(opcode inside {OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR})
                || (opcode == BRANCH && func3[2:1] == 2'b01)
                || (opcode == OP && func7b50[0] && (func7b50[1] || func3[2]));
`else
  assign illegal = 1'b0;
`endif
endmodule

// File: rtl/ex_stage_controller.sv
// ex_stage_controller: EX-stage control decode with one-shot multiplier start; EX_ILLEGAL_DETECT_EN enables illegal.
module ex_stage_controller
  import ex_ctrl_pkg::*;
#(
  parameter int ifuresctl_N = 2,
  localparam int SW = (ifuresctl_N > 2) ? $clog2(ifuresctl_N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    opcode,
  input  logic [2:0]    func3,
  input  logic [1:0]    func7b50,
  input  logic          instr_valid,
  output logic [3:0]    aluctl,
  output logic [1:0]    mulctl,
  output logic          mulstart,
  output logic [SW-1:0] ifuresctl,
  output logic          illegal
);
  logic [3:0] dec_alu;
  logic       dec_ill;
  logic       is_mul;
  logic       arm_q, arm_d;
  alu_op_decoder u_dec (
    .opcode   (opcode),
    .func3    (func3),
    .func7b50 (func7b50),
    .aluctl   (dec_alu),
    .illegal  (dec_ill)
  );
  assign is_mul    = opcode == OP && func7b50 == 2'b01 && !func3[2];
  assign aluctl    = rst ? ALU_ADD : dec_alu;
  assign mulctl    = rst ? MU_MUL : mu_op_e'(func3[1:0]);
  assign ifuresctl = (!rst && is_mul) ? SW'(RES_MU) : SW'(RES_ALU);
  assign illegal   = !rst && dec_ill;
  assign mulstart  = !rst && instr_valid && is_mul && arm_q;
  // re-arm whenever the EX slot empties so a held instruction pulses only once
  assign arm_d     = rst || !instr_valid || (arm_q && !mulstart);
  always_ff @(posedge clk) arm_q <= arm_d;
endmodule

// File: tb/tb_ex_stage_controller.sv
// tb_ex_stage_controller: directed stimulus with literal checks plus a per-cycle reference model compare.
module tb_ex_stage_controller;
  logic       clk = 0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [1:0] func7b50;
  logic       instr_valid;
  logic [3:0] aluctl;
  logic [1:0] mulctl;
  logic       mulstart;
  logic [0:0] ifuresctl;
  logic       illegal;
  int checks = 0;
  int errors = 0;
  logic pulsed = 0;
`ifdef EX_ILLEGAL_DETECT_EN
  localparam bit ILL_EN = 1;
`else
  localparam bit ILL_EN = 0;
`endif
  ex_stage_controller #(.ifuresctl_N(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7b50(func7b50),
    .instr_valid(instr_valid), .aluctl(aluctl), .mulctl(mulctl), .mulstart(mulstart),
    .ifuresctl(ifuresctl), .illegal(illegal)
  );
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [3:0] arith(input logic [2:0] f3, input logic alt);
    int base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    return 4'(base[f3] + ((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0));
  endfunction

  // alu_dc marks encodings where the ALU code is left unspecified
  task automatic decode(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7,
                        output logic [3:0] alu, output logic alu_dc, output logic mu, output logic ill);
    alu = 0; alu_dc = 0; mu = 0; ill = 0;
    case (op)
      7'b0110011:
        if (f7 == 2'b01 && !f3[2]) mu = 1;
        else if (f7[0]) begin ill = 1; alu_dc = 1; end
        else alu = arith(f3, f7[1]);
      7'b0010011: alu = arith(f3, f3 == 3'd5 && f7[1]);
      7'b0110111: alu = 4'd10;
      7'b0010111, 7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111: alu = 0;
      7'b1100011:
        if (f3[2:1] == 2'b01) begin ill = 1; alu_dc = 1; end
        else alu = f3[2] ? (f3[1] ? 4'd4 : 4'd3) : 4'd1;
      default: ill = 1;
    endcase
  endtask

  always @(posedge clk) begin
    logic [3:0] a; logic dc, mu, il;
    decode(opcode, func3, func7b50, a, dc, mu, il);
    pulsed <= !rst && instr_valid && (pulsed || mu);
  end

  always @(negedge clk) begin
    logic [3:0] a; logic dc, mu, il;
    decode(opcode, func3, func7b50, a, dc, mu, il);
    if (rst) begin
      chk("m_rst_alu", aluctl, 0);
      chk("m_rst_mulctl", mulctl, 0);
      chk("m_rst_ifu", ifuresctl, 0);
      chk("m_rst_ill", illegal, 0);
      chk("m_rst_ms", mulstart, 0);
    end else begin
      if (!dc) chk("m_alu", aluctl, mu ? 0 : a);
      if (mu) chk("m_mulctl", mulctl, func3[1:0]);
      chk("m_ifu", ifuresctl, mu);
      chk("m_ill", illegal, ILL_EN && il);
      chk("m_ms", mulstart, instr_valid && mu && !pulsed);
    end
  end

  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] f7,
                     input logic v, input logic r);
    @(posedge clk);
    #1 opcode = op; func3 = f3; func7b50 = f7; instr_valid = v; rst = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; opcode = 7'b0110011; func3 = 3'd0; func7b50 = 2'b01; instr_valid = 1;
    @(negedge clk);
    chk("rst_alu", aluctl, 0); chk("rst_ms", mulstart, 0); chk("rst_ifu", ifuresctl, 0);
    cyc(7'b0110011, 3'd0, 2'b00, 1, 0); chk("add", aluctl, 4'b0000); chk("add_ifu", ifuresctl, 0); chk("add_ms", mulstart, 0);
    cyc(7'b0110011, 3'd0, 2'b10, 1, 0); chk("sub", aluctl, 4'b0001);
    cyc(7'b0010011, 3'd5, 2'b10, 1, 0); chk("srai", aluctl, 4'b0111);
    cyc(7'b0010011, 3'd0, 2'b10, 1, 0); chk("addi", aluctl, 4'b0000);
    cyc(7'b0110011, 3'd3, 2'b01, 0, 0); chk("idle_ms", mulstart, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(7'b0110011, 3'd3, 2'b01, 1, 0);
      chk("mulhu_ms", mulstart, i == 0); chk("mulhu_ctl", mulctl, 2'b11); chk("mulhu_ifu", ifuresctl, 1);
    end
    cyc(7'b0110011, 3'd0, 2'b01, 0, 0); chk("drop_ms", mulstart, 0);
    cyc(7'b0110011, 3'd0, 2'b01, 1, 0); chk("mul_ms1", mulstart, 1);
    cyc(7'b0110011, 3'd0, 2'b01, 1, 0); chk("mul_ms2", mulstart, 0);
    cyc(7'b0110011, 3'd3, 2'b01, 1, 0); chk("chg_ms", mulstart, 0);
    cyc(7'b1100011, 3'd6, 2'b00, 1, 0); chk("bltu", aluctl, 4'b0100); chk("bltu_ill", illegal, 0);
    cyc(7'b1100011, 3'd2, 2'b00, 1, 0); chk("br010_ill", illegal, ILL_EN);
    cyc(7'b0110111, 3'd0, 2'b00, 1, 0); chk("lui", aluctl, 4'b1010);
    cyc(7'b0110011, 3'd0, 2'b01, 0, 0);
    cyc(7'b0110011, 3'd0, 2'b01, 1, 1); chk("rmul_ms", mulstart, 0); chk("rmul_ifu", ifuresctl, 0); chk("rmul_ctl", mulctl, 0);
    cyc(7'b0110011, 3'd1, 2'b01, 1, 0); chk("rel_ms", mulstart, 1);
    cyc(7'b0110011, 3'd1, 2'b01, 1, 0); chk("rel_ms2", mulstart, 0);
    cyc(7'b0110011, 3'd1, 2'b01, 1, 1); chk("mid_rst_ms", mulstart, 0); chk("mid_rst_alu", aluctl, 0);
    cyc(7'b0110011, 3'd1, 2'b01, 1, 0); chk("mid_rel_ms", mulstart, 1);
    cyc(7'b0110011, 3'd4, 2'b01, 0, 0);
    cyc(7'b0110011, 3'd4, 2'b01, 1, 0); chk("div_ill", illegal, ILL_EN); chk("div_ms", mulstart, 0); chk("div_ifu", ifuresctl, 0);
    cyc(7'b0110011, 3'd0, 2'b11, 1, 0); chk("f7_11_ill", illegal, ILL_EN); chk("f7_11_ms", mulstart, 0);
    cyc(7'b1111111, 3'd0, 2'b00, 1, 0); chk("unk_ill", illegal, ILL_EN); chk("unk_alu", aluctl, 0);
    cyc(7'b0010111, 3'd7, 2'b10, 1, 0); chk("auipc", aluctl, 0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
